mem_stream_ctrl: RTL and testbench

MEM_STREAM_CTRL -- requirements
Module: mem_stream_ctrl

---
 rtl/mem_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_stream_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: loads a burst into a single-port RAM,
// then drains it back out as a stream with credit-based reads.
module mem_stream_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 64,
  parameter int LOGSIZE = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic [LOGSIZE-1:0] mem_addr,
  output logic               mem_wr_en,
  output logic [WIDTH-1:0]   mem_data_in,
  input  logic [WIDTH-1:0]   mem_data_out,
  output logic               trunc
);

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  localparam logic [LOGSIZE:0]   ONE  = 1;
  localparam logic [LOGSIZE-1:0] WTOP = LOGSIZE'(SIZE - 1);

  state_t             state;
  logic [LOGSIZE-1:0] wr_ptr;
  logic [LOGSIZE:0]   rd_ptr;
  logic [LOGSIZE:0]   len;
  logic [1:0]         credits;
  logic [1:0]         cnt;
  logic               rd_pend;
  logic               rd_pend_last;
  logic [WIDTH-1:0]   d0, d1;
  logic               l0, l1;

  logic accept;
  logic issue;
  logic pop;
  logic push;
  logic done;
  logic wr_full;

  // Handshakes, read issue and memory port steering.
  always_comb begin
    s_ready     = reset_n && (state == LOAD);
    accept      = s_valid && s_ready;
    m_valid     = (cnt != 2'd0);
    m_data      = m_valid ? d0 : '0;
    m_last      = m_valid && l0;
    pop         = m_valid && m_ready;
    done        = pop && l0;
    push        = rd_pend;
    wr_full     = (wr_ptr == WTOP);
    issue       = (state == DRAIN) && (rd_ptr < len)
                  && ((credits != 2'd0) || pop);
    mem_wr_en   = accept;
    mem_data_in = accept ? s_data : '0;
    mem_addr    = (state == DRAIN) ? rd_ptr[LOGSIZE-1:0]
                                   : wr_ptr;
  end

  // Load/drain sequencing, pointers and read credits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LOAD;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len          <= '0;
      credits      <= 2'd2;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      trunc        <= 1'b0;
    end else begin
      trunc        <= 1'b0;
      rd_pend      <= issue;
      rd_pend_last <= issue && ((rd_ptr + ONE) == len);
      unique case (state)
        LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s_last || wr_full) begin
              state  <= DRAIN;
              wr_ptr <= '0;
              len    <= {1'b0, wr_ptr} + ONE;
              trunc  <= !s_last;
            end
          end
        end
        DRAIN: begin
          if (issue) rd_ptr <= rd_ptr + ONE;
          credits <= credits - {1'b0, issue}
                             + {1'b0, pop};
          if (done) begin
            state   <= LOAD;
            rd_ptr  <= '0;
            len     <= '0;
            credits <= 2'd2;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Two-entry output FIFO; d0/l0 is always the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= mem_data_out;
            l0 <= rd_pend_last;
          end else begin
            d1 <= mem_data_out;
            l1 <= rd_pend_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= mem_data_out;
            l0 <= rd_pend_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= mem_data_out;
            l1 <= rd_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// tb_mem_stream_ctrl: directed and randomized bursts checked
// against a queue-based model of load/drain behaviour.
module tb_mem_stream_ctrl;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int LG = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [LG-1:0] mem_addr;
  logic          mem_wr_en;
  logic [W-1:0]  mem_data_in;
  logic [W-1:0]  mem_data_out;
  logic          trunc;

  always #5 clk = ~clk;

  mem_stream_ctrl #(.WIDTH(W), .SIZE(N), .LOGSIZE(LG)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .trunc        (trunc)
  );

  // Single-port RAM with one-cycle read latency.
  logic [W-1:0] ram [N];
  logic [W-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_data_in;
    ram_q <= ram[mem_addr];
  end
  assign mem_data_out = ram_q;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } word_t;

  word_t src[$];
  word_t expq[$];

  int tests = 0;
  int fails = 0;
  bit loading;
  int wcount;
  int popped;
  int burst_len;
  int drain_age;
  bit exp_trunc;
  bit prev_stall;
  logic [W-1:0] prev_data;
  logic prev_last;
  int ready_mode;
  int low_left;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    src.delete();
    expq.delete();
    loading    = 1'b1;
    wcount     = 0;
    popped     = 0;
    burst_len  = 0;
    drain_age  = 0;
    exp_trunc  = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic push_word(logic [W-1:0] d, logic l);
    word_t w;
    w.d = d;
    w.l = l;
    src.push_back(w);
  endtask

  // One clock: drive at negedge, sample 1ns later.
  task automatic cycle();
    word_t w;
    word_t e;
    bit was_loading;
    w = '0;
    if (src.size() > 0) begin
      w       = src[0];
      s_valid = 1'b1;
      s_data  = w.d;
      s_last  = w.l;
    end else begin
      s_valid = !loading && ($urandom_range(0, 1) == 1);
      s_data  = W'($urandom);
      s_last  = ($urandom_range(0, 1) == 1);
    end
    if (ready_mode == 0) m_ready = 1'b1;
    else if (low_left > 0) begin
      m_ready = 1'b0;
      low_left--;
    end else m_ready = ($urandom_range(0, 1) == 1);
    #1;
    was_loading = loading;
    if (!loading) drain_age++;
    chk("s_ready", s_ready, loading);
    chk("trunc", trunc, exp_trunc);
    chk("wr_en", mem_wr_en, loading && s_valid);
    if (mem_wr_en) begin
      chk("wr_addr", mem_addr, wcount);
      chk("wr_data", mem_data_in, s_data);
    end
    if (loading) chk("idle_mvalid", m_valid, 0);
    else begin
      if (drain_age < 2) chk("early_mvalid", m_valid, 0);
      else if (drain_age == 2 || ready_mode == 0)
        chk("stream_mvalid", m_valid, 1);
      if (burst_len < N)
        chk("outstanding",
            (int'(mem_addr) - popped) <= 2, 1);
    end
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    exp_trunc = 1'b0;
    if (loading && s_valid) begin
      expq.push_back(w);
      void'(src.pop_front());
      wcount++;
      if (w.l || wcount == N) begin
        loading   = 1'b0;
        burst_len = wcount;
        exp_trunc = !w.l;
        drain_age = -1;
        popped    = 0;
      end
    end
    if (!was_loading && m_valid && m_ready) begin
      chk("pop_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("m_data", m_data, e.d);
        chk("m_last", m_last, expq.size() == 0);
        popped++;
        if (expq.size() == 0) begin
          loading = 1'b1;
          wcount  = 0;
        end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(negedge clk);
  endtask

  task automatic run_until_idle(int bound);
    int n = 0;
    while (!(loading && src.size() == 0 && expq.size() == 0)
           && n < bound) begin
      cycle();
      n++;
    end
    chk("idle_timeout", n < bound, 1);
  endtask

  task automatic run_until_drain(int bound);
    int n = 0;
    while (loading && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < bound, 1);
  endtask

  task automatic run_until_pops(int target, int bound);
    int n = 0;
    while (!(!loading && popped >= target) && n < bound) begin
      cycle();
      n++;
    end
    chk("pops_timeout", n < bound, 1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_trunc"}, trunc, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_din"}, mem_data_in, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    s_valid    = 1'b1;
    s_data     = 16'hA5A5;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    ready_mode = 0;
    low_left   = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Three-word burst, always ready.
    push_word(16'h0011, 1'b0);
    push_word(16'h0022, 1'b0);
    push_word(16'h0033, 1'b1);
    run_until_idle(50);

    // Single-word burst.
    push_word(16'hBEEF, 1'b1);
    run_until_idle(50);
    cycle();

    // Overlong burst truncated at SIZE, 65th word held off.
    for (int i = 0; i < N; i++) push_word(W'(i), 1'b0);
    push_word(16'h0040, 1'b1);
    run_until_idle(400);

    // Randomly stalled drains, first with a long low run.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = (k == 0) ? 8 : $urandom_range(1, 20);
      for (int i = 0; i < n; i++)
        push_word(W'($urandom), i == n - 1);
      ready_mode = 0;
      run_until_drain(100);
      ready_mode = 1;
      low_left   = (k == 0) ? 5 : $urandom_range(0, 3);
      run_until_idle(300);
    end
    ready_mode = 0;

    // Reset in the middle of a drain.
    for (int i = 0; i < 8; i++)
      push_word(W'(16'h0100 + i), i == 7);
    run_until_pops(3, 100);
    reset_n = 1'b0;
    s_valid = 1'b1;
    #1;
    chk_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    #1;
    chk_reset_outputs("hold");
    @(negedge clk);
    reset_n = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 1);
    @(negedge clk);
    push_word(16'h1234, 1'b0);
    push_word(16'h5678, 1'b1);
    run_until_idle(50);

    // Back-to-back bursts offered without a gap.
    for (int i = 0; i < 4; i++)
      push_word(W'(16'h0A00 + i), i == 3);
    for (int i = 0; i < 5; i++)
      push_word(W'(16'h0B00 + i), i == 4);
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
